ball_controller: RTL and testbench
==================================

# ball_controller

Ball-motion engine for the pong datapath, and the counterpart of the paddle block. The paddle consumes ball Y position and a range strobe and answers with a hit. This block generates ball X/Y position, advances it at a divided step rate and bounces it off the top and bottom walls. It opens a hit-check window toward the left or right paddle and, from the paddle's answer, either reflects the ball or scores a point and re-serves.

## Interface
- STEP_DIV, 100000: clock cycles per ball step (bench overrides to 4)
- SERVE_STEPS, 32: steps the ball rests at centre before a serve
- LEFT_X, 1: column of left paddle
- RIGHT_X, 126: column of right paddle
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces the reset state immediately
- start  in  1  level; sampled in IDLE to begin play
- pause  in  1  level; freezes step counter and FSM while high
- hitLeft  in  1  isHit from left paddle
- hitRight  in  1  isHit from right paddle
- ballX  out  7  ball column, registered
- ballY  out  7  ball row, registered (drives paddle ball_y)
- inPaddleRangeLeft  out  1  check window open toward left paddle
- inPaddleRangeRight  out  1  check window open toward right paddle
- scoreLeft  out  1  one-cycle pulse: left player scored (right missed)
- scoreRight  out  1  one-cycle pulse: right player scored (left missed)
- active  out  1  high in MOVE, CHECK and SERVE

## Operation
- Reset values:
  - ballX=64, ballY=64; dirX=1 (right), dirY=1 (down, increasing Y).
  - All strobes and pulses 0; active=0; step counter 0; state IDLE.
- Step event: counter==STEP_DIV-1 and pause low. Counter wraps to 0 on that edge; otherwise it increments. Counter is held at 0 in IDLE and CHECK.
- IDLE: ball at centre. start high -> SERVE, serve counter 0.
- SERVE: ball held at (64,64). Each step event increments the serve counter. The step event with serve counter==SERVE_STEPS-1 -> MOVE; dirX is kept as set on entry.
- MOVE, on each step event:
  - X moves by ±1 per dirX.
  - Y moves by ±1 per dirY. Wall bounce: if ballY==127 with dirY=1, or ballY==0 with dirY=0, flip dirY and move Y one row in the new direction (127->126, 0->1). Y never leaves 0..127.
  - If new ballX==LEFT_X with dirX=0 -> CHECK_L. If new ballX==RIGHT_X with dirX=1 -> CHECK_R. X arrival and Y bounce on the same step both apply.
- CHECK_L / CHECK_R: exactly 2 cycles, ball frozen.
  - inPaddleRangeLeft (or Right) is high for both cycles.
  - The matching hit input is sampled on the second cycle's closing edge; the paddle may register isHit one cycle.
  - Hit: flip dirX -> MOVE. The next step moves the ball to LEFT_X+1 (or RIGHT_X-1).
  - Miss: pulse scoreRight (CHECK_L) or scoreLeft (CHECK_R) for one cycle. Ball returns to centre, serve counter 0 -> SERVE. dirX points toward the player who missed; dirY is kept.
- Hit inputs are ignored outside the matching CHECK state. The opposite side's hit is always ignored.
- pause high: all state, counters and outputs hold, including an open check window. CHECK cycle counting resumes when pause drops.
- start is ignored outside IDLE. There is no return to IDLE except through reset.

## Timing
- Position outputs change only on the step-event edge; latency is 0 cycles from that edge.
- CHECK is entered on the same edge that lands ballX on the paddle column. inPaddleRange rises on that edge and falls 2 edges later.
- A score pulse is asserted for the cycle after the CHECK exit edge. ballX/ballY show centre from that same edge.
- First ball movement after start:
  - 1 edge into SERVE, then SERVE_STEPS×STEP_DIV cycles to MOVE, then STEP_DIV more cycles to the first move.
  - With pause low, start to first move = 1 + (SERVE_STEPS+1)×STEP_DIV cycles.
- Reset asserted mid-CHECK or mid-SERVE: outputs drop to reset values asynchronously, with no score pulse. Play resumes only via a new start after reset deasserts.

## Test plan
- Reset/idle:
  - Hold reset low, then release with start low for 100 cycles.
  - Required: ballX=64, ballY=64, all strobes 0, active=0 throughout.
- Serve timing (STEP_DIV=4, SERVE_STEPS=2):
  - Raise start.
  - Required: active rises the next edge; ballX becomes 65 and ballY 65 exactly 13 cycles after the start edge.
- Right hit:
  - Run until ballX=126; drive hitRight=1 during CHECK.
  - Required: inPaddleRangeRight high exactly 2 cycles, no score pulse, next step ballX=125.
- Left miss:
  - Reach ballX=1 with hitLeft=0.
  - Required: one-cycle scoreRight pulse; ball back at (64,64) in SERVE with dirX=0. The first post-serve step gives ballX=63.
- Wall bounce:
  - Force ballY to reach 127 while dirY=1.
  - Required: next step ballY=126 and subsequent rows decrease. A simultaneous X paddle arrival still opens CHECK on the same edge.
- Pause and reset mid-CHECK:
  - Pause high in CHECK_L for 10 cycles: range stays high and ball frozen.
  - Then reset low: range drops immediately, no score pulse, ball at (64,64).

Source files
------------

// File: rtl/ball_controller_if.sv
// Paddle-facing bundle of the ball engine: ball position, check windows,
// paddle hit answers, score pulses and the play-active flag.
interface ball_controller_if;
  logic [6:0] ballX;
  logic [6:0] ballY;
  logic       inPaddleRangeLeft;
  logic       inPaddleRangeRight;
  logic       hitLeft;
  logic       hitRight;
  logic       scoreLeft;
  logic       scoreRight;
  logic       active;

  modport master (
    output ballX, ballY, inPaddleRangeLeft, inPaddleRangeRight,
           scoreLeft, scoreRight, active,
    input  hitLeft, hitRight
  );

  modport slave (
    input  ballX, ballY, inPaddleRangeLeft, inPaddleRangeRight,
           scoreLeft, scoreRight, active,
    output hitLeft, hitRight
  );
endinterface

// File: rtl/ball_controller.sv
// Pong ball-motion engine: serves from centre, steps the ball at a divided
// rate, bounces off the walls and resolves paddle hits or misses.
module ball_controller #(
  parameter int STEP_DIV    = 100000,
  parameter int SERVE_STEPS = 32,
  parameter int LEFT_X      = 1,
  parameter int RIGHT_X     = 126
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  ball_controller_if.master bus
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int VW = (SERVE_STEPS > 1) ? $clog2(SERVE_STEPS) : 1;
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
  localparam logic [VW-1:0] SERVE_LAST = VW'(SERVE_STEPS - 1);
  localparam logic [6:0]    LEFT_POS   = 7'(LEFT_X);
  localparam logic [6:0]    RIGHT_POS  = 7'(RIGHT_X);
  localparam logic [6:0]    CENTRE     = 7'd64;

  typedef enum logic [2:0] {IDLE, SERVE, MOVE, CHECK_L, CHECK_R} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] step_cnt, step_cnt_nxt;
  logic [VW-1:0] serve_cnt, serve_cnt_nxt;
  logic          check_cnt, check_cnt_nxt;
  logic [6:0]    ball_x, ball_x_nxt;
  logic [6:0]    ball_y, ball_y_nxt;
  logic          dir_x, dir_x_nxt;
  logic          dir_y, dir_y_nxt;
  logic          score_l, score_l_nxt;
  logic          score_r, score_r_nxt;
  logic          step_evt;
  logic          hit;
  logic [6:0]    move_x, move_y;
  logic          move_dir_y;

  assign step_evt = (state == SERVE || state == MOVE) && !pause && (step_cnt == STEP_LAST);
  assign hit      = (state == CHECK_L) ? bus.hitLeft : bus.hitRight;

  // Candidate position for the next step; a wall bounce reflects within the same step.
  always_comb begin
    move_x     = dir_x ? ball_x + 7'd1 : ball_x - 7'd1;
    move_y     = dir_y ? ball_y + 7'd1 : ball_y - 7'd1;
    move_dir_y = dir_y;
    if (dir_y && ball_y == 7'd127) begin
      move_dir_y = 1'b0;
      move_y     = 7'd126;
    end else if (!dir_y && ball_y == 7'd0) begin
      move_dir_y = 1'b1;
      move_y     = 7'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    step_cnt_nxt  = '0;
    serve_cnt_nxt = serve_cnt;
    check_cnt_nxt = check_cnt;
    ball_x_nxt    = ball_x;
    ball_y_nxt    = ball_y;
    dir_x_nxt     = dir_x;
    dir_y_nxt     = dir_y;
    score_l_nxt   = 1'b0;
    score_r_nxt   = 1'b0;

    if (state == SERVE || state == MOVE) begin
      if (pause)
        step_cnt_nxt = step_cnt;
      else if (step_cnt != STEP_LAST)
        step_cnt_nxt = step_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = SERVE;
          serve_cnt_nxt = '0;
        end
      end
      SERVE: begin
        if (step_evt) begin
          if (serve_cnt == SERVE_LAST)
            state_nxt = MOVE;
          else
            serve_cnt_nxt = serve_cnt + 1'b1;
        end
      end
      MOVE: begin
        if (step_evt) begin
          ball_x_nxt = move_x;
          ball_y_nxt = move_y;
          dir_y_nxt  = move_dir_y;
          if (move_x == LEFT_POS && !dir_x) begin
            state_nxt     = CHECK_L;
            check_cnt_nxt = 1'b0;
          end else if (move_x == RIGHT_POS && dir_x) begin
            state_nxt     = CHECK_R;
            check_cnt_nxt = 1'b0;
          end
        end
      end
      CHECK_L, CHECK_R: begin
        if (!pause) begin
          if (!check_cnt) begin
            check_cnt_nxt = 1'b1;
          end else begin
            check_cnt_nxt = 1'b0;
            if (hit) begin
              dir_x_nxt = ~dir_x;
              state_nxt = MOVE;
            end else begin
              // Re-serve toward the player who missed.
              score_r_nxt   = (state == CHECK_L);
              score_l_nxt   = (state == CHECK_R);
              dir_x_nxt     = (state == CHECK_R);
              ball_x_nxt    = CENTRE;
              ball_y_nxt    = CENTRE;
              serve_cnt_nxt = '0;
              state_nxt     = SERVE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      step_cnt  <= '0;
      serve_cnt <= '0;
      check_cnt <= 1'b0;
      ball_x    <= CENTRE;
      ball_y    <= CENTRE;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      score_l   <= 1'b0;
      score_r   <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_cnt  <= step_cnt_nxt;
      serve_cnt <= serve_cnt_nxt;
      check_cnt <= check_cnt_nxt;
      ball_x    <= ball_x_nxt;
      ball_y    <= ball_y_nxt;
      dir_x     <= dir_x_nxt;
      dir_y     <= dir_y_nxt;
      score_l   <= score_l_nxt;
      score_r   <= score_r_nxt;
    end
  end

  assign bus.ballX              = ball_x;
  assign bus.ballY              = ball_y;
  assign bus.inPaddleRangeLeft  = (state == CHECK_L);
  assign bus.inPaddleRangeRight = (state == CHECK_R);
  assign bus.scoreLeft          = score_l;
  assign bus.scoreRight         = score_r;
  assign bus.active             = (state != IDLE);

endmodule

// File: tb/tb_ball_controller.sv
// Directed bench for ball_controller: serve timing, right hit, left miss,
// wall bounce with simultaneous paddle arrival, pause and reset in a check.
module tb_ball_controller;

  logic clk;
  logic reset;
  logic start;
  logic pause;
  int   n_checks;
  int   n_fail;

  ball_controller_if bus ();
  ball_controller_if bus2 ();

  ball_controller #(.STEP_DIV(4), .SERVE_STEPS(2), .LEFT_X(1), .RIGHT_X(126)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .pause (pause),
    .bus   (bus.master)
  );

  // Second engine whose left paddle sits where the ball bounces off the top wall.
  ball_controller #(.STEP_DIV(4), .SERVE_STEPS(2), .LEFT_X(124), .RIGHT_X(126)) dut2 (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .pause (pause),
    .bus   (bus2.master)
  );

  assign bus2.hitRight = bus.hitRight;
  assign bus2.hitLeft  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic st, input logic pa, input logic hl, input logic hr);
    start        = st;
    pause        = pa;
    bus.hitLeft  = hl;
    bus.hitRight = hr;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] snap();
    return {13'd0, bus.ballX, bus.ballY, bus.inPaddleRangeLeft, bus.inPaddleRangeRight,
            bus.scoreLeft, bus.scoreRight, bus.active};
  endfunction

  localparam logic [31:0] IDLE_SNAP = {13'd0, 7'd64, 7'd64, 5'b00000};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    check_output("reset_state", snap(), IDLE_SNAP);

    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check_output("idle_hold", snap(), IDLE_SNAP);
    end

    // Serve: start edge is edge 1; first move lands on edge 13.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    check_output("active_after_start", 32'(bus.active), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(11);
    check_output("serve_x_edge12", 32'(bus.ballX), 32'd64);
    tick(1);
    check_output("first_move_x", 32'(bus.ballX), 32'd65);
    check_output("first_move_y", 32'(bus.ballY), 32'd65);

    // Right paddle arrival on edge 257 with hitRight held high.
    tick(243);
    check_output("pre_right_x", 32'(bus.ballX), 32'd125);
    tick(1);
    check_output("right_arrive_x", 32'(bus.ballX), 32'd126);
    check_output("right_arrive_y", 32'(bus.ballY), 32'd126);
    check_output("range_r_cyc1", 32'(bus.inPaddleRangeRight), 32'd1);
    check_output("range_l_quiet", 32'(bus.inPaddleRangeLeft), 32'd0);
    tick(1);
    check_output("range_r_cyc2", 32'(bus.inPaddleRangeRight), 32'd1);
    check_output("right_frozen_x", 32'(bus.ballX), 32'd126);
    tick(1);
    check_output("range_r_closed", 32'(bus.inPaddleRangeRight), 32'd0);
    check_output("no_score_hit", {30'd0, bus.scoreLeft, bus.scoreRight}, 32'd0);
    tick(1);
    check_output("no_score_hit2", {30'd0, bus.scoreLeft, bus.scoreRight}, 32'd0);
    check_output("hold_after_hit", 32'(bus.ballX), 32'd126);
    tick(3);
    check_output("after_hit_x", 32'(bus.ballX), 32'd125);
    check_output("after_hit_y", 32'(bus.ballY), 32'd127);
    check_output("dut2_x_125", 32'(bus2.ballX), 32'd125);
    check_output("dut2_no_range", 32'(bus2.inPaddleRangeLeft), 32'd0);

    // Top wall bounce; dut2 reaches its left column on the same step.
    tick(4);
    check_output("bounce_x", 32'(bus.ballX), 32'd124);
    check_output("bounce_y", 32'(bus.ballY), 32'd126);
    check_output("dut2_bounce_y", 32'(bus2.ballY), 32'd126);
    check_output("dut2_arrive_x", 32'(bus2.ballX), 32'd124);
    check_output("dut2_range_l", 32'(bus2.inPaddleRangeLeft), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);
    check_output("descend_y", 32'(bus.ballY), 32'd125);
    check_output("descend_x", 32'(bus.ballX), 32'd123);

    // Left miss on edge 759.
    tick(487);
    check_output("pre_left_x", 32'(bus.ballX), 32'd2);
    tick(1);
    check_output("left_arrive_x", 32'(bus.ballX), 32'd1);
    check_output("left_arrive_y", 32'(bus.ballY), 32'd3);
    check_output("range_l_cyc1", 32'(bus.inPaddleRangeLeft), 32'd1);
    tick(1);
    check_output("range_l_cyc2", 32'(bus.inPaddleRangeLeft), 32'd1);
    check_output("no_early_score", 32'(bus.scoreRight), 32'd0);
    tick(1);
    check_output("miss_snapshot", snap(), {13'd0, 7'd64, 7'd64, 5'b00011});
    tick(1);
    check_output("score_pulse_end", {30'd0, bus.scoreLeft, bus.scoreRight}, 32'd0);
    tick(10);
    check_output("serve_hold_x", 32'(bus.ballX), 32'd64);
    tick(1);
    check_output("reserve_x", 32'(bus.ballX), 32'd63);
    check_output("reserve_y", 32'(bus.ballY), 32'd63);

    // Second left arrival on edge 1021, then pause inside the check window.
    tick(247);
    check_output("pre_left2_x", 32'(bus.ballX), 32'd2);
    tick(1);
    check_output("left2_snapshot", snap(), {13'd0, 7'd1, 7'd1, 5'b10001});
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_output("paused_check", snap(), {13'd0, 7'd1, 7'd1, 5'b10001});
    end

    reset = 1'b0;
    #1;
    check_output("async_reset", snap(), IDLE_SNAP);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    check_output("reset_held", snap(), IDLE_SNAP);
    reset = 1'b1;
    tick(5);
    check_output("idle_after_reset", snap(), IDLE_SNAP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
